dmem_port_rv: RTL and testbench

Data-memory responder for the RISC-V core: services the load/store requests produced by the instruction decode stage (write flag, sign-extend flag, access size, byte address, store data) against a single-port, word-wide synchronous SRAM. It performs lane selection, sign/zero extension, read-modify-write for sub-word stores and alignment checking, then returns load data and an exception code over a valid/ready response channel. It sits between the execute stage and the data SRAM macro.

---
 rtl/dmem_port_rv.sv | 179 +++++++++++++++++
 tb/tb_dmem_port_rv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_rv.sv
// Data-memory responder: load/store against a word-wide synchronous SRAM with lane select,
// extension and sub-word read-modify-write. Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses.
`ifndef MEM_ACCESS_BYTE
`define MEM_ACCESS_BYTE      2'b00
`endif
`ifndef MEM_ACCESS_HALF_WORD
`define MEM_ACCESS_HALF_WORD 2'b01
`endif
`ifndef MEM_ACCESS_WORD
`define MEM_ACCESS_WORD      2'b10
`endif
`ifndef EXCEPTION_SUCCESS
`define EXCEPTION_SUCCESS       4'h0
`endif
`ifndef EXCEPTION_ILLEGAL_INSTR
`define EXCEPTION_ILLEGAL_INSTR 4'h1
`endif
`ifndef EXCEPTION_MISALIGNED
`define EXCEPTION_MISALIGNED    4'h2
`endif

module dmem_port_rv #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  iwClk,
    input  logic                  iwRst,
    input  logic                  iwReqValid,
    output logic                  owReqReady,
    input  logic                  iwReqWrite,
    input  logic                  iwReqSignExtend,
    input  logic [1:0]            iwReqAccess,
    input  logic [31:0]           iwReqAddr,
    input  logic [31:0]           iwReqWData,
    output logic                  owRespValid,
    input  logic                  iwRespReady,
    output logic [31:0]           orRespRData,
    output logic [3:0]            orRespException,
    output logic [ADDR_WIDTH-1:0] owMemAddr,
    output logic                  owMemWe,
    output logic [31:0]           owMemWData,
    input  logic [31:0]           iwMemRData
);
    localparam int unsigned BYTE_ADDR_WIDTH = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} stateT;

    stateT                      state;
    stateT                      nextState;
    logic                       rWrite;
    logic                       rSignExtend;
    logic [1:0]                 rAccess;
    logic [BYTE_ADDR_WIDTH-1:0] rAddr;
    logic [31:0]                rWData;

    logic        reqFire;
    logic        accessReserved;
    logic        alignFault;
    logic [1:0]  reqAddrLow;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadData;
    logic [31:0] mergedWord;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^iwReqAddr[31:BYTE_ADDR_WIDTH];

    assign owReqReady  = (state == IDLE) && !iwRst;
    assign owRespValid = (state == RESP);
    assign owMemWe     = (state == WRITE);
    assign owMemAddr   = rAddr[BYTE_ADDR_WIDTH-1:2];
    assign owMemWData  = rWData;
    assign reqFire     = iwReqValid && owReqReady;

    assign accessReserved = (iwReqAccess != `MEM_ACCESS_BYTE) &&
                            (iwReqAccess != `MEM_ACCESS_HALF_WORD) &&
                            (iwReqAccess != `MEM_ACCESS_WORD);

`ifdef DMEM_ALIGN_CHECK_EN
    assign alignFault = ((iwReqAccess == `MEM_ACCESS_HALF_WORD) && iwReqAddr[0]) ||
                        ((iwReqAccess == `MEM_ACCESS_WORD) && (iwReqAddr[1:0] != 2'b00));
    assign reqAddrLow = iwReqAddr[1:0];
`else
    // Without checking, misaligned requests are snapped down to their natural alignment.
    assign alignFault = 1'b0;
    always_comb begin
        reqAddrLow = iwReqAddr[1:0];
        if (iwReqAccess == `MEM_ACCESS_HALF_WORD) reqAddrLow = {iwReqAddr[1], 1'b0};
        else if (iwReqAccess == `MEM_ACCESS_WORD) reqAddrLow = 2'b00;
    end
`endif

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (reqFire) begin
                    if (accessReserved || alignFault)      nextState = RESP;
                    else if (!iwReqWrite)                  nextState = READ;
                    else if (iwReqAccess == `MEM_ACCESS_WORD) nextState = WRITE;
                    else                                   nextState = READ;
                end
            end
            READ:    nextState = MERGE;
            MERGE:   nextState = rWrite ? WRITE : RESP;
            WRITE:   nextState = RESP;
            RESP:    if (iwRespReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Little-endian lane extraction and sub-word merge of the SRAM read word.
    always_comb begin
        byteLane = iwMemRData[7:0];
        case (rAddr[1:0])
            2'b01:   byteLane = iwMemRData[15:8];
            2'b10:   byteLane = iwMemRData[23:16];
            2'b11:   byteLane = iwMemRData[31:24];
            default: byteLane = iwMemRData[7:0];
        endcase
        halfLane = rAddr[1] ? iwMemRData[31:16] : iwMemRData[15:0];

        loadData = iwMemRData;
        if (rAccess == `MEM_ACCESS_BYTE)
            loadData = rSignExtend ? {{24{byteLane[7]}}, byteLane} : {24'h0, byteLane};
        else if (rAccess == `MEM_ACCESS_HALF_WORD)
            loadData = rSignExtend ? {{16{halfLane[15]}}, halfLane} : {16'h0, halfLane};

        mergedWord = iwMemRData;
        if (rAccess == `MEM_ACCESS_BYTE) begin
            case (rAddr[1:0])
                2'b01:   mergedWord[15:8]  = rWData[7:0];
                2'b10:   mergedWord[23:16] = rWData[7:0];
                2'b11:   mergedWord[31:24] = rWData[7:0];
                default: mergedWord[7:0]   = rWData[7:0];
            endcase
        end else if (rAccess == `MEM_ACCESS_HALF_WORD) begin
            if (rAddr[1]) mergedWord[31:16] = rWData[15:0];
            else          mergedWord[15:0]  = rWData[15:0];
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            rWrite          <= 1'b0;
            rSignExtend     <= 1'b0;
            rAccess         <= 2'b00;
            rAddr           <= '0;
            rWData          <= 32'h0;
            orRespRData     <= 32'h0;
            orRespException <= `EXCEPTION_SUCCESS;
        end else begin
            case (state)
                IDLE: begin
                    if (reqFire) begin
                        rWrite          <= iwReqWrite;
                        rSignExtend     <= iwReqSignExtend;
                        rAccess         <= iwReqAccess;
                        rAddr           <= {iwReqAddr[BYTE_ADDR_WIDTH-1:2], reqAddrLow};
                        rWData          <= iwReqWData;
                        orRespRData     <= 32'h0;
                        orRespException <= accessReserved ? `EXCEPTION_ILLEGAL_INSTR :
                                           alignFault     ? `EXCEPTION_MISALIGNED :
                                                            `EXCEPTION_SUCCESS;
                    end
                end
                MERGE: begin
                    if (rWrite) rWData      <= mergedWord;
                    else        orRespRData <= loadData;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_rv.sv
// Directed self-checking bench for dmem_port_rv with a behavioural synchronous SRAM.
`ifndef MEM_ACCESS_BYTE
`define MEM_ACCESS_BYTE      2'b00
`endif
`ifndef MEM_ACCESS_HALF_WORD
`define MEM_ACCESS_HALF_WORD 2'b01
`endif
`ifndef MEM_ACCESS_WORD
`define MEM_ACCESS_WORD      2'b10
`endif
`ifndef EXCEPTION_SUCCESS
`define EXCEPTION_SUCCESS       4'h0
`endif
`ifndef EXCEPTION_ILLEGAL_INSTR
`define EXCEPTION_ILLEGAL_INSTR 4'h1
`endif
`ifndef EXCEPTION_MISALIGNED
`define EXCEPTION_MISALIGNED    4'h2
`endif

module tb_dmem_port_rv;
    localparam int unsigned ADDR_WIDTH = 10;

    logic                  iwClk = 1'b0;
    logic                  iwRst;
    logic                  iwReqValid;
    logic                  owReqReady;
    logic                  iwReqWrite;
    logic                  iwReqSignExtend;
    logic [1:0]            iwReqAccess;
    logic [31:0]           iwReqAddr;
    logic [31:0]           iwReqWData;
    logic                  owRespValid;
    logic                  iwRespReady;
    logic [31:0]           orRespRData;
    logic [3:0]            orRespException;
    logic [ADDR_WIDTH-1:0] owMemAddr;
    logic                  owMemWe;
    logic [31:0]           owMemWData;
    logic [31:0]           iwMemRData;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    int vectors = 0;
    int miscompares = 0;

    dmem_port_rv #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .iwClk(iwClk), .iwRst(iwRst),
        .iwReqValid(iwReqValid), .owReqReady(owReqReady),
        .iwReqWrite(iwReqWrite), .iwReqSignExtend(iwReqSignExtend),
        .iwReqAccess(iwReqAccess), .iwReqAddr(iwReqAddr), .iwReqWData(iwReqWData),
        .owRespValid(owRespValid), .iwRespReady(iwRespReady),
        .orRespRData(orRespRData), .orRespException(orRespException),
        .owMemAddr(owMemAddr), .owMemWe(owMemWe), .owMemWData(owMemWData),
        .iwMemRData(iwMemRData)
    );

    always #5 iwClk = ~iwClk;

    always @(posedge iwClk) begin
        if (owMemWe) mem[owMemAddr] <= owMemWData;
        iwMemRData <= mem[owMemAddr];
    end

    // Drives one request, returns response fields, response latency and write-pulse count.
    task automatic doReq(input logic w, input logic s, input logic [1:0] acc,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic [3:0] exc,
                         output int lat, output int wes);
        int guard;
        @(negedge iwClk);
        iwReqValid = 1'b1; iwReqWrite = w; iwReqSignExtend = s;
        iwReqAccess = acc; iwReqAddr = addr; iwReqWData = wd;
        guard = 0;
        while (!owReqReady && guard < 20) begin @(negedge iwClk); guard++; end
        @(posedge iwClk);
        @(negedge iwClk);
        iwReqValid = 1'b0;
        lat = 1; wes = 0;
        while (!owRespValid && lat < 20) begin
            if (owMemWe) wes++;
            @(negedge iwClk);
            lat++;
        end
        if (!owRespValid) lat = -1;
        rdata = orRespRData; exc = orRespException;
        iwRespReady = 1'b1;
        @(posedge iwClk);
        #1 iwRespReady = 1'b0;
    endtask

    task automatic test_reset();
        iwRst = 1'b1;
        repeat (2) @(posedge iwClk);
        @(negedge iwClk);
        vectors++; if (owReqReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", owReqReady); end
        vectors++; if (owRespValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", owRespValid); end
        vectors++; if (orRespRData !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", orRespRData); end
        vectors++; if (orRespException !== `EXCEPTION_SUCCESS) begin miscompares++; $display("FAIL reset_exc got %h want %h", orRespException, `EXCEPTION_SUCCESS); end
        vectors++; if (owMemWe !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", owMemWe); end
        vectors++; if (owMemAddr !== '0) begin miscompares++; $display("FAIL reset_memaddr got %h want 0", owMemAddr); end
        vectors++; if (owMemWData !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", owMemWData); end
        iwRst = 1'b0;
        #1;
        vectors++; if (owReqReady !== 1'b1) begin miscompares++; $display("FAIL release_ready got %b want 1", owReqReady); end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic [3:0] ex; int lat; int wes;
        doReq(1'b1, 1'b0, `MEM_ACCESS_WORD, 32'h100, 32'hDEADBEEF, rd, ex, lat, wes);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d want 2", lat); end
        vectors++; if (wes !== 1) begin miscompares++; $display("FAIL sw_we_pulses got %0d want 1", wes); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL sw_rdata got %h want 0", rd); end
        vectors++; if (ex !== `EXCEPTION_SUCCESS) begin miscompares++; $display("FAIL sw_exc got %h want 0", ex); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_WORD, 32'h100, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        vectors++; if (ex !== `EXCEPTION_SUCCESS) begin miscompares++; $display("FAIL lw_exc got %h want 0", ex); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lw_latency got %0d want 3", lat); end
        vectors++; if (wes !== 0) begin miscompares++; $display("FAIL lw_we_pulses got %0d want 0", wes); end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic [3:0] ex; int lat; int wes;
        doReq(1'b1, 1'b0, `MEM_ACCESS_BYTE, 32'h102, 32'hFFFFFF5A, rd, ex, lat, wes);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL sb_latency got %0d want 4", lat); end
        vectors++; if (wes !== 1) begin miscompares++; $display("FAIL sb_we_pulses got %0d want 1", wes); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_BYTE, 32'h102, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'h0000005A) begin miscompares++; $display("FAIL lbu_rdata got %h want 0000005a", rd); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_WORD, 32'h100, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'hDE5ABEEF) begin miscompares++; $display("FAIL lw_after_sb got %h want de5abeef", rd); end
        doReq(1'b1, 1'b0, `MEM_ACCESS_HALF_WORD, 32'h106, 32'hABCD1234, rd, ex, lat, wes);
        vectors++; if (mem[10'h041] !== 32'h12340000) begin miscompares++; $display("FAIL sh_upper_lane got %h want 12340000", mem[10'h041]); end
    endtask

    task automatic test_extension();
        logic [31:0] rd; logic [3:0] ex; int lat; int wes;
        doReq(1'b1, 1'b0, `MEM_ACCESS_WORD, 32'h200, 32'h80FF7F00, rd, ex, lat, wes);
        doReq(1'b0, 1'b1, `MEM_ACCESS_BYTE, 32'h201, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'h0000007F) begin miscompares++; $display("FAIL lb_201 got %h want 0000007f", rd); end
        doReq(1'b0, 1'b1, `MEM_ACCESS_BYTE, 32'h203, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_203 got %h want ffffff80", rd); end
        doReq(1'b0, 1'b1, `MEM_ACCESS_HALF_WORD, 32'h202, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_202 got %h want ffff80ff", rd); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_HALF_WORD, 32'h202, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'h000080FF) begin miscompares++; $display("FAIL lhu_202 got %h want 000080ff", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic [3:0] ex; int lat; int wes;
        doReq(1'b0, 1'b0, `MEM_ACCESS_WORD, 32'h101, 32'h0, rd, ex, lat, wes);
`ifdef DMEM_ALIGN_CHECK_EN
        vectors++; if (ex !== `EXCEPTION_MISALIGNED) begin miscompares++; $display("FAIL mis_lw_exc got %h want 2", ex); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mis_lw_rdata got %h want 0", rd); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mis_lw_latency got %0d want 1", lat); end
        doReq(1'b1, 1'b0, `MEM_ACCESS_HALF_WORD, 32'h101, 32'h00001111, rd, ex, lat, wes);
        vectors++; if (wes !== 0) begin miscompares++; $display("FAIL mis_sh_we got %0d want 0", wes); end
        vectors++; if (mem[10'h040] !== 32'hDE5ABEEF) begin miscompares++; $display("FAIL mis_sh_mem got %h want de5abeef", mem[10'h040]); end
`else
        vectors++; if (rd !== 32'hDE5ABEEF) begin miscompares++; $display("FAIL mis_lw_rdata got %h want de5abeef", rd); end
        vectors++; if (ex !== `EXCEPTION_SUCCESS) begin miscompares++; $display("FAIL mis_lw_exc got %h want 0", ex); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mis_lw_latency got %0d want 3", lat); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_HALF_WORD, 32'h203, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'h000080FF) begin miscompares++; $display("FAIL mis_lhu_rdata got %h want 000080ff", rd); end
`endif
    endtask

    task automatic test_illegal_hold();
        int guard;
        @(negedge iwClk);
        iwReqValid = 1'b1; iwReqWrite = 1'b1; iwReqSignExtend = 1'b0;
        iwReqAccess = 2'b11; iwReqAddr = 32'h100; iwReqWData = 32'h12345678;
        guard = 0;
        while (!owReqReady && guard < 20) begin @(negedge iwClk); guard++; end
        @(posedge iwClk);
        for (int c = 0; c < 6; c++) begin
            @(negedge iwClk);
            iwReqValid = 1'b0;
            vectors++; if (owRespValid !== 1'b1) begin miscompares++; $display("FAIL ill_valid cyc%0d got %b want 1", c, owRespValid); end
            vectors++; if (orRespException !== `EXCEPTION_ILLEGAL_INSTR) begin miscompares++; $display("FAIL ill_exc cyc%0d got %h want %h", c, orRespException, `EXCEPTION_ILLEGAL_INSTR); end
            vectors++; if (orRespRData !== 32'h0) begin miscompares++; $display("FAIL ill_rdata cyc%0d got %h want 0", c, orRespRData); end
            vectors++; if (owReqReady !== 1'b0) begin miscompares++; $display("FAIL ill_ready cyc%0d got %b want 0", c, owReqReady); end
            vectors++; if (owMemWe !== 1'b0) begin miscompares++; $display("FAIL ill_we cyc%0d got %b want 0", c, owMemWe); end
        end
        iwRespReady = 1'b1;
        @(posedge iwClk);
        #1 iwRespReady = 1'b0;
        @(negedge iwClk);
        vectors++; if (owRespValid !== 1'b0) begin miscompares++; $display("FAIL ill_after_valid got %b want 0", owRespValid); end
        vectors++; if (owReqReady !== 1'b1) begin miscompares++; $display("FAIL ill_after_ready got %b want 1", owReqReady); end
        vectors++; if (mem[10'h040] !== 32'hDE5ABEEF) begin miscompares++; $display("FAIL ill_mem got %h want de5abeef", mem[10'h040]); end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic [3:0] ex; int lat; int wes; int guard;
        doReq(1'b1, 1'b0, `MEM_ACCESS_WORD, 32'h300, 32'hCAFEF00D, rd, ex, lat, wes);
        @(negedge iwClk);
        iwReqValid = 1'b1; iwReqWrite = 1'b1; iwReqSignExtend = 1'b0;
        iwReqAccess = `MEM_ACCESS_HALF_WORD; iwReqAddr = 32'h300; iwReqWData = 32'h00001234;
        guard = 0;
        while (!owReqReady && guard < 20) begin @(negedge iwClk); guard++; end
        @(posedge iwClk);
        @(negedge iwClk);
        iwReqValid = 1'b0;
        @(negedge iwClk);
        iwRst = 1'b1;
        #1;
        vectors++; if (owReqReady !== 1'b0) begin miscompares++; $display("FAIL rmw_rst_ready got %b want 0", owReqReady); end
        vectors++; if (owRespValid !== 1'b0) begin miscompares++; $display("FAIL rmw_rst_valid got %b want 0", owRespValid); end
        vectors++; if (owMemWe !== 1'b0) begin miscompares++; $display("FAIL rmw_rst_we got %b want 0", owMemWe); end
        vectors++; if (owMemAddr !== '0) begin miscompares++; $display("FAIL rmw_rst_memaddr got %h want 0", owMemAddr); end
        vectors++; if (owMemWData !== 32'h0) begin miscompares++; $display("FAIL rmw_rst_wdata got %h want 0", owMemWData); end
        vectors++; if (orRespException !== `EXCEPTION_SUCCESS) begin miscompares++; $display("FAIL rmw_rst_exc got %h want 0", orRespException); end
        @(posedge iwClk);
        @(negedge iwClk);
        iwRst = 1'b0;
        #1;
        vectors++; if (owReqReady !== 1'b1) begin miscompares++; $display("FAIL rmw_release_ready got %b want 1", owReqReady); end
        vectors++; if (mem[10'h0C0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rmw_mem got %h want cafef00d", mem[10'h0C0]); end
        doReq(1'b0, 1'b0, `MEM_ACCESS_WORD, 32'h300, 32'h0, rd, ex, lat, wes);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rmw_lw got %h want cafef00d", rd); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rmw_lw_latency got %0d want 3", lat); end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h0;
        iwRst = 1'b1; iwReqValid = 1'b0; iwReqWrite = 1'b0; iwReqSignExtend = 1'b0;
        iwReqAccess = 2'b00; iwReqAddr = 32'h0; iwReqWData = 32'h0; iwRespReady = 1'b0;
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_extension();
        test_misaligned();
        test_illegal_hold();
        test_reset_mid_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
